// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target.
// The OV5640 answers on 0x78 for writes and 0x79 for reads.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB_HI,
    ST_SUB_HI_ACK,
    ST_SUB_LO,
    ST_SUB_LO_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_WAIT_STOP
  } sccb_tgt_state_t;

  localparam logic [7:0] OV5640_SCCB_ADDR    = 8'h78;
  localparam logic [7:0] OV5640_SCCB_ADDR_RD = 8'h79;

  function automatic logic addr_match(
    input logic [7:0] rx,
    input logic [7:0] dev
  );
    return rx[7:1] == dev[7:1];
  endfunction

endpackage

// File: rtl/sccb_target_if.sv
// Pad pins and register port of the SCCB target.
// The slave modport is the target's view; master is its environment.
interface sccb_target_if;
  logic        scl_i;
  logic        sda_i;
  logic        sda_oe;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata;
  logic        busy;

  modport slave (
    input  scl_i, sda_i, reg_rdata,
    output sda_oe, reg_addr, reg_wdata,
    output reg_we, reg_re, busy
  );

  modport master (
    output scl_i, sda_i, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata,
    input  reg_we, reg_re, busy
  );
endinterface

// File: rtl/sccb_glitch_filter.sv
// 2-FF synchronizer followed by a stable-count filter.
// Output idles high, matching a released open-drain line.
module sccb_glitch_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam logic [3:0] LIM = 4'(FILTER_LEN - 1);

  logic [1:0] sync;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      cnt  <= '0;
      q    <= 1'b1;
    end else begin
      sync <= {sync[0], d};
      if (sync[1] == q) begin
        cnt <= '0;
      end else if (cnt == LIM) begin
        q   <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sccb_target.sv
// SCCB responder: decodes 3-phase writes and 2-phase reads,
// turning each accepted access into a one-cycle register strobe.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DEVICE_ADDR = OV5640_SCCB_ADDR,
  parameter int unsigned FILTER_LEN  = 3
) (
  input logic          clk,
  input logic          rest,
  sccb_target_if.slave bus
);

  logic scl_f, sda_f, scl_q, sda_q;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start, stop;

  sccb_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .rst(rest), .d(bus.scl_i), .q(scl_f)
  );

  sccb_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .rst(rest), .d(bus.sda_i), .q(sda_f)
  );

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign sda_rise = sda_f & ~sda_q;
  assign sda_fall = ~sda_f & sda_q;
  assign start    = sda_fall & scl_f;
  assign stop     = sda_rise & scl_f;

  sccb_tgt_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d, byte_in;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rw_q, rw_d, oe_q, oe_d;
  logic        we_q, we_d, re_q, re_d;
  logic        busy_q, busy_d, rd_pend_q;

  assign byte_in = {shift_q[6:0], sda_f};

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      oe_q      <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      busy_q    <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      scl_q     <= scl_f;
      sda_q     <= sda_f;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      re_q      <= re_d;
      busy_q    <= busy_d;
      rd_pend_q <= re_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = rd_pend_q ? bus.reg_rdata : shift_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    busy_d  = busy_q;
    if (start) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (stop) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ADDR: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (addr_match(byte_in, DEVICE_ADDR)) begin
              state_d = ST_ADDR_ACK;
              rw_d    = byte_in[0];
              busy_d  = 1'b1;
            end else begin
              state_d = ST_WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        ST_SUB_HI, ST_SUB_LO, ST_WDATA: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            unique case (state_q)
              ST_SUB_HI: state_d = ST_SUB_HI_ACK;
              ST_SUB_LO: state_d = ST_SUB_LO_ACK;
              default:   state_d = ST_WDATA_ACK;
            endcase
          end
        end
        // First fall drives the ACK, second fall ends the 9th clock.
        ST_ADDR_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
            re_d = rw_q;
          end else if (rw_q) begin
            state_d = ST_RDATA;
            oe_d    = ~shift_q[7];
          end else begin
            state_d = ST_SUB_HI;
            oe_d    = 1'b0;
          end
        end
        ST_SUB_HI_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d         = 1'b1;
            addr_d[15:8] = shift_q;
          end else begin
            state_d = ST_SUB_LO;
            oe_d    = 1'b0;
          end
        end
        ST_SUB_LO_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d        = 1'b1;
            addr_d[7:0] = shift_q;
          end else begin
            state_d = ST_WDATA;
            oe_d    = 1'b0;
          end
        end
        ST_WDATA_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d    = 1'b1;
            wdata_d = shift_q;
            we_d    = 1'b1;
          end else begin
            state_d = ST_WAIT_STOP;
            oe_d    = 1'b0;
          end
        end
        // cnt counts master rises; 8 means the master owns bit 9.
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd8) begin
              cnt_d = '0;
              if (sda_f) state_d = ST_WAIT_STOP;
              else       re_d    = 1'b1;
            end
          end else if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              oe_d = ~shift_q[7];
            end else if (cnt_q == 4'd8) begin
              oe_d = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        ST_WAIT_STOP: oe_d = 1'b0;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.sda_oe    = oe_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sccb_target.sv
// Bit-banged SCCB master against a byte-level register model.
// Directed cases first, then randomized write/read-back rounds.
module tb_sccb_target;
  import sccb_pkg::*;

  logic clk = 1'b0;
  logic rest = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic glitch = 1'b0;
  bit   glitch_en = 1'b0;
  bit   glitch_sub = 1'b0;
  int   q = 25;
  int   n_cmp = 0;
  int   n_bad = 0;

  sccb_target_if bus();

  sccb_target #(
    .DEVICE_ADDR(OV5640_SCCB_ADDR),
    .FILTER_LEN(3)
  ) dut (
    .clk(clk),
    .rest(rest),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.scl_i = m_scl | glitch;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  logic [7:0] rf  [int];
  logic [7:0] mdl [int];

  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a == 16'h300A) return 8'h56;
    return a[15:8] ^ a[7:0] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] rf_get(input logic [15:0] a);
    return rf.exists(int'(a)) ? rf[int'(a)] : init_val(a);
  endfunction

  function automatic logic [7:0] mdl_get(input logic [15:0] a);
    return mdl.exists(int'(a)) ? mdl[int'(a)] : init_val(a);
  endfunction

  int          we_n = 0, re_n = 0, long_n = 0;
  logic [15:0] we_addr = '0, re_addr = '0;
  logic [7:0]  we_data = '0;
  logic        we_p = 1'b0, re_p = 1'b0;
  logic        oe_seen = 1'b0, busy_seen = 1'b0;

  always @(negedge clk) begin
    if (bus.reg_we) begin
      we_n++;
      we_addr = bus.reg_addr;
      we_data = bus.reg_wdata;
      rf[int'(bus.reg_addr)] = bus.reg_wdata;
    end
    if (bus.reg_re) begin
      re_n++;
      re_addr = bus.reg_addr;
    end
    if ((bus.reg_we && we_p) || (bus.reg_re && re_p)) long_n++;
    we_p = bus.reg_we;
    re_p = bus.reg_re;
    if (bus.sda_oe) oe_seen = 1'b1;
    if (bus.busy) busy_seen = 1'b1;
    bus.reg_rdata = rf_get(bus.reg_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start;
    m_sda = 1'b1; wq(q);
    m_scl = 1'b1; wq(q);
    m_sda = 1'b0; wq(q);
    m_scl = 1'b0; wq(q);
  endtask

  task automatic m_stop;
    m_sda = 1'b0; wq(q);
    m_scl = 1'b1; wq(q);
    m_sda = 1'b1; wq(q);
  endtask

  task automatic tx_bit(input logic b);
    m_sda = b;
    if (glitch_en) begin
      wq(3); glitch = 1'b1; wq(2); glitch = 1'b0; wq(q - 5);
    end else begin
      wq(q);
    end
    m_scl = 1'b1; wq(2 * q);
    m_scl = 1'b0; wq(q);
  endtask

  task automatic rx_bit(output logic b);
    m_sda = 1'b1; wq(q);
    m_scl = 1'b1; wq(q);
    b = bus.sda_i; wq(q);
    m_scl = 1'b0; wq(q);
  endtask

  task automatic tx_byte(input logic [7:0] d, output logic nack);
    for (int i = 7; i >= 0; i--) tx_bit(d[i]);
    rx_bit(nack);
  endtask

  task automatic rx_byte(output logic [7:0] d, input logic ack_it);
    for (int i = 7; i >= 0; i--) rx_bit(d[i]);
    tx_bit(~ack_it);
  endtask

  task automatic wr_txn(input logic [7:0] dev, input logic [15:0] sub,
                        input logic [7:0] data, input bit extra,
                        output logic [4:0] acks);
    logic a;
    acks = '1;
    m_start;
    tx_byte(dev, a); acks[0] = a;
    if (!a) begin
      glitch_en = glitch_sub;
      tx_byte(sub[15:8], a); acks[1] = a;
      tx_byte(sub[7:0], a);  acks[2] = a;
      glitch_en = 1'b0;
      tx_byte(data, a); acks[3] = a;
      if (extra) begin
        tx_byte(8'hA5, a); acks[4] = a;
      end
    end
    m_stop;
  endtask

  task automatic set_ptr(input logic [15:0] sub, input bit stop_after,
                         output logic [2:0] acks);
    logic a;
    m_start;
    tx_byte(OV5640_SCCB_ADDR, a); acks[0] = a;
    tx_byte(sub[15:8], a);        acks[1] = a;
    tx_byte(sub[7:0], a);         acks[2] = a;
    if (stop_after) m_stop;
  endtask

  task automatic rd_bytes(input int n, output logic [7:0] d0,
                          output logic [7:0] d1, output logic nack);
    d0 = '0;
    d1 = '0;
    m_start;
    tx_byte(OV5640_SCCB_ADDR_RD, nack);
    if (!nack) begin
      rx_byte(d0, n > 1);
      if (n > 1) rx_byte(d1, 1'b0);
    end
    m_stop;
  endtask

  initial begin
    logic [4:0]  a5;
    logic [2:0]  a3;
    logic [7:0]  d0, d1, data;
    logic [6:0]  a7;
    logic [7:0]  dev;
    logic [15:0] sub;
    logic        nk;
    int          we0, re0, n;
    bit          bad, rep;

    wq(4);
    chk("rst_oe", bus.sda_oe, 0);
    chk("rst_addr", bus.reg_addr, 0);
    chk("rst_wdata", bus.reg_wdata, 0);
    chk("rst_strobes", {bus.reg_we, bus.reg_re}, 0);
    chk("rst_busy", bus.busy, 0);
    rest = 1'b0;
    wq(4);

    we0 = we_n; re0 = re_n; busy_seen = 1'b0;
    wr_txn(8'h78, 16'h3008, 8'h82, 1'b1, a5);
    mdl[16'h3008] = 8'h82;
    chk("wr_acks", a5, 5'b10000);
    chk("wr_we_cnt", we_n - we0, 1);
    chk("wr_addr", we_addr, 16'h3008);
    chk("wr_data", we_data, 8'h82);
    chk("wr_re_cnt", re_n - re0, 0);
    chk("wr_busy_seen", busy_seen, 1);
    chk("wr_busy_end", bus.busy, 0);

    we0 = we_n; re0 = re_n;
    set_ptr(16'h300A, 1'b1, a3);
    rd_bytes(1, d0, d1, nk);
    chk("rd_ptr_acks", a3, 0);
    chk("rd_err", nk, 0);
    chk("rd_data", d0, mdl_get(16'h300A));
    chk("rd_re_cnt", re_n - re0, 1);
    chk("rd_re_addr", re_addr, 16'h300A);
    chk("rd_we_cnt", we_n - we0, 0);

    we0 = we_n; re0 = re_n; oe_seen = 1'b0; busy_seen = 1'b0;
    wr_txn(8'h42, 16'h1234, 8'h55, 1'b0, a5);
    chk("bad_err", a5, 5'b11111);
    chk("bad_oe_seen", oe_seen, 0);
    chk("bad_busy_seen", busy_seen, 0);
    chk("bad_strobes", (we_n - we0) + (re_n - re0), 0);

    we0 = we_n; glitch_sub = 1'b1;
    wr_txn(8'h78, 16'h3C1D, 8'h9E, 1'b0, a5);
    glitch_sub = 1'b0;
    mdl[16'h3C1D] = 8'h9E;
    chk("gl_acks", a5, 5'b10000);
    chk("gl_we_cnt", we_n - we0, 1);
    chk("gl_addr", we_addr, 16'h3C1D);
    chk("gl_data", we_data, 8'h9E);

    m_start;
    tx_byte(8'h78, nk);
    tx_byte(8'h31, nk);
    for (int i = 0; i < 4; i++) tx_bit(1'b0);
    chk("mid_busy", bus.busy, 1);
    chk("mid_addr_hi", bus.reg_addr[15:8], 8'h31);
    @(negedge clk);
    #2 rest = 1'b1;
    #1;
    chk("mid_rst_oe", bus.sda_oe, 0);
    chk("mid_rst_addr", bus.reg_addr, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_out", {bus.reg_we, bus.reg_re, bus.reg_wdata}, 0);
    m_sda = 1'b1; m_scl = 1'b1;
    wq(5);
    rest = 1'b0;
    wq(10);
    we0 = we_n;
    wr_txn(8'h78, 16'h3103, 8'h11, 1'b0, a5);
    mdl[16'h3103] = 8'h11;
    chk("post_rst_acks", a5, 5'b10000);
    chk("post_rst_we", we_n - we0, 1);
    chk("post_rst_addr", we_addr, 16'h3103);
    chk("post_rst_data", we_data, 8'h11);

    re0 = re_n;
    set_ptr(16'h3008, 1'b0, a3);
    rd_bytes(1, d0, d1, nk);
    chk("rs_acks", {a3, nk}, 0);
    chk("rs_data", d0, mdl_get(16'h3008));
    chk("rs_re_addr", re_addr, 16'h3008);
    chk("rs_re_cnt", re_n - re0, 1);

    for (int it = 0; it < 4; it++) begin
      q    = $urandom_range(10, 25);
      bad  = ($urandom_range(0, 3) == 0);
      sub  = 16'($urandom);
      data = 8'($urandom);
      dev  = 8'h78;
      if (bad) begin
        do a7 = 7'($urandom); while (a7 == 7'h3C);
        dev = {a7, 1'($urandom)};
      end
      we0 = we_n; re0 = re_n; oe_seen = 1'b0;
      wr_txn(dev, sub, data, 1'b0, a5);
      if (bad) begin
        chk("rnd_bad_acks", a5, 5'b11111);
        chk("rnd_bad_oe", oe_seen, 0);
        chk("rnd_bad_we", we_n - we0, 0);
      end else begin
        mdl[int'(sub)] = data;
        chk("rnd_acks", a5, 5'b10000);
        chk("rnd_we_cnt", we_n - we0, 1);
        chk("rnd_we_addr", we_addr, sub);
        chk("rnd_we_data", we_data, data);
        n   = $urandom_range(1, 2);
        rep = 1'($urandom_range(0, 1));
        re0 = re_n;
        set_ptr(sub, !rep, a3);
        rd_bytes(n, d0, d1, nk);
        chk("rnd_rd_acks", {a3, nk}, 0);
        chk("rnd_rd_d0", d0, mdl_get(sub));
        if (n > 1) chk("rnd_rd_d1", d1, mdl_get(sub));
        chk("rnd_re_cnt", re_n - re0, n);
        chk("rnd_re_addr", re_addr, sub);
      end
    end

    chk("strobe_width", long_n, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sccb_target.md
# sccb_target

SCCB responder that emulates the OV5640 control port at the far end of the camera bus. It lets the FPGA stand in for a sensor in simulation and loopback tests, and lets it expose an on-chip register file to an external SCCB master. It decodes 3-phase writes and 2-phase reads on SCL/SDA and drives SDA open-drain for ACK and read data. Each accepted access becomes a single-cycle strobe on a simple register port.

## Interface
- DEVICE_ADDR, 8'h78: 8-bit write address; bit 0 is ignored on match (read address is DEVICE_ADDR|1).
- FILTER_LEN, 3: consecutive clk samples a synchronized input must hold before the filtered value changes; range 1–15.
- clk  input  1  system clock; must be at least 8× SCL.
- rest  input  1  asynchronous active-high reset.
- scl_i  input  1  raw SCL from pad.
- sda_i  input  1  raw SDA from pad.
- sda_oe  output  1  1 = pull SDA low; 0 = release. The pad drives `sda_oe ? 1'b0 : 1'bz`.
- reg_addr  output  16  register pointer.
- reg_wdata  output  8  write data; valid while reg_we is high.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read strobe.
- reg_rdata  input  8  read data; must be valid on the cycle after reg_re.
- busy  output  1  high from an addressed START until STOP.

## Operation
- **Input conditioning.** Each input passes through a 2-FF synchronizer, then the glitch filter, giving scl_f and sda_f.
  - scl_rise, scl_fall, sda_rise and sda_fall are one-cycle pulses derived from the filtered values.
  - START is sda_fall while scl_f is 1. STOP is sda_rise while scl_f is 1.
- **Priority.** START and STOP are evaluated in every state and take priority over bit handling.
  - START (including a repeated START) → ADDR, bit counter cleared, sda_oe = 0.
  - STOP → IDLE, sda_oe = 0.
- **Bit sampling and driving.** sda_f is sampled on scl_rise, MSB first. sda_oe changes only on scl_fall.
- **States**
  - IDLE: waits for START.
  - ADDR: shifts in 8 bits.
    - On the 8th scl_rise, bits [7:1] are compared with DEVICE_ADDR[7:1].
    - Match → ADDR_ACK and latch rw = bit 0.
    - Mismatch → WAIT_STOP.
  - ADDR_ACK: on the next scl_fall, set sda_oe = 1.
    - If rw = 1, pulse reg_re on that same cycle and load the shift register from reg_rdata one cycle later.
    - On the following scl_fall (end of the 9th clock): rw = 0 → SUB_HI with sda_oe = 0; rw = 1 → RDATA with sda_oe = !shift[7].
  - SUB_HI, SUB_LO: each receives 8 bits, then ACKs exactly as in ADDR_ACK.
    - The received bytes load reg_addr[15:8] and reg_addr[7:0] respectively, on the ACK-start scl_fall.
  - WDATA: receives 8 bits, then ACKs.
    - reg_wdata is the received byte and reg_we pulses on the ACK-start scl_fall.
    - After the ACK → WAIT_STOP; further bytes are ignored and not ACKed.
  - RDATA: on each scl_fall, shift and drive the next bit. After the 8th bit, release SDA for the master's 9th bit.
    - Master NACK (sda_f = 1 on the 9th scl_rise) → WAIT_STOP.
    - Master ACK → pulse reg_re again at the same reg_addr, reload the shift register, continue in RDATA.
  - WAIT_STOP: keeps SDA released until STOP or START.
- **Pointer behaviour.**
  - reg_addr persists across STOP and is not auto-incremented.
  - A 2-phase write (address + sub-address, then STOP) followed by a read transaction reads from that pointer.
- **busy:** set on the address match and cleared on STOP or on a mismatch.

## Timing
- Reset values: sda_oe 0, reg_we 0, reg_re 0, reg_addr 16'h0000, reg_wdata 8'h00, busy 0, state IDLE, filters initialised to 1.
- Latency from pad to edge pulse: 2 + FILTER_LEN clk cycles.
- Filter behaviour: pulses shorter than FILTER_LEN cycles are suppressed.
- sda_oe changes 1 cycle after scl_fall. This gives SDA hold of at least 3 + FILTER_LEN clk cycles after the pad SCL falls.
- reg_we and reg_re are high for exactly 1 cycle per access. reg_rdata is sampled at reg_re + 1.
- Reset asserted mid-transfer releases SDA asynchronously and the next START is served normally.

## Structure
- Shared package `sccb_pkg` holds:
  - the state enum `sccb_tgt_state_t`;
  - the OV5640 default addresses 8'h78/8'h79 (`OV5640_SCCB_ADDR`).
- Sub-module `sccb_glitch_filter` contains the 2-FF synchronizer and stable-count filter (parameter FILTER_LEN, reset value 1). It is instantiated twice, once for SCL and once for SDA.

## Test plan
- **Write.** Master (SCL_DIV 100) writes 0x3008 = 0x82 to 0x78 → four ACKs observed; one reg_we with reg_addr 0x3008 and reg_wdata 0x82; no reg_re.
- **Read.** Master writes sub-address 0x300A, STOP, START, 0x79; reg_rdata = 0x56 → one reg_re at 0x300A; master receives 0x56; error stays 0.
- **Wrong address.** Master addresses 0x42 → sda_oe never asserted; no strobes; master error = 1; busy remains 0.
- **Glitches.** 2-cycle glitches on SCL during the sub-address byte with FILTER_LEN 3 → ignored; the write completes with the correct address.
- **Reset mid-byte.** Assert rest during SUB_LO → sda_oe = 0 immediately; all outputs at reset values; a subsequent write of 0x3103 = 0x11 succeeds.
- **Repeated START.** Repeated START after SUB_LO, followed by a read → state returns to ADDR; the read returns data from the new pointer.
